// File: rtl/dump_uart_tx.sv
// dump_uart_tx: latches one channel sample per request and sends it as an 8N1 UART frame
module dump_uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_dump,
    input  logic [1:0] dump_chan,
    input  logic [7:0] ch1_data,
    input  logic [7:0] ch2_data,
    input  logic [7:0] ch3_data,
    output logic       dump_sent,
    output logic       tx_busy,
    output logic       TX
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state_q;
    logic [CW-1:0]   baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            busy_q;
    logic [7:0]      byte_d;
    logic            baud_end;
    always_comb begin
        byte_d   = dump_chan == 2'd0 ? ch1_data :
                   dump_chan == 2'd1 ? ch2_data :
                   dump_chan == 2'd2 ? ch3_data : 8'h00;
        baud_end = baud_cnt_q == LAST;
    end
    assign dump_sent = (state_q == STOP) && baud_end;
    assign tx_busy   = busy_q;
    assign TX        = tx_q;
    // TX is registered one step ahead: each bit boundary loads the value of the bit that follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            baud_cnt_q <= (state_q == IDLE || baud_end) ? '0 : baud_cnt_q + 1'b1;
            case (state_q)
                IDLE: if (send_dump) begin
                    shift_q <= byte_d;
                    state_q <= START;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (baud_end) begin
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                    tx_q      <= shift_q[0];
                end
                DATA: if (baud_end) begin
                    shift_q   <= shift_q >> 1;
                    tx_q      <= (bit_cnt_q == 3'd7) ? 1'b1 : shift_q[1];
                    state_q   <= (bit_cnt_q == 3'd7) ? STOP : DATA;
                    bit_cnt_q <= (bit_cnt_q == 3'd7) ? bit_cnt_q : bit_cnt_q + 3'd1;
                end
                STOP: if (baud_end) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dump_uart_tx.sv
// tb_dump_uart_tx: directed vectors for the dump UART transmitter with BAUD_DIV=4
module tb_dump_uart_tx;
    localparam int BD = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_dump = 1'b0;
    logic [1:0] dump_chan = 2'd0;
    logic [7:0] ch1_data = 8'h00, ch2_data = 8'h00, ch3_data = 8'h00;
    logic       dump_sent, tx_busy, TX;
    int         n_vec = 0, n_bad = 0;

    dump_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .send_dump(send_dump), .dump_chan(dump_chan),
        .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
        .dump_sent(dump_sent), .tx_busy(tx_busy), .TX(TX)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] c1, c2, c3;
        logic [7:0] exp;
        bit         hold;
    } vec_t;

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, k, act, exp);
        end
    endtask

    function automatic logic exp_tx(input int k, input logic [7:0] b);
        int i = (k - 1) / BD;
        return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
    endfunction

    task automatic start_req(input logic [1:0] chan, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        dump_chan = chan;
        ch1_data  = c1;
        ch2_data  = c2;
        ch3_data  = c3;
        send_dump = 1'b1;
    endtask

    // Call at the negedge where the request was raised; checks all 10*BD cycles of the frame.
    task automatic frame(input logic [7:0] b, input bit hold, input bit mutate);
        for (int k = 1; k <= 10 * BD; k++) begin
            @(negedge clk);
            chk("tx", k, {7'd0, TX}, {7'd0, exp_tx(k, b)});
            chk("busy", k, {7'd0, tx_busy}, 8'd1);
            chk("sent", k, {7'd0, dump_sent}, {7'd0, k == 10 * BD});
            if (k == 1 && !hold) send_dump = 1'b0;
            if (k == 10 * BD) send_dump = 1'b0;
            if (k == 2 && mutate) begin
                ch3_data  = 8'hAA;
                dump_chan = 2'd0;
            end
        end
    endtask

    task automatic idle_chk(input string name);
        @(negedge clk);
        chk({name, "_tx"}, 0, {7'd0, TX}, 8'd1);
        chk({name, "_busy"}, 0, {7'd0, tx_busy}, 8'd0);
        chk({name, "_sent"}, 0, {7'd0, dump_sent}, 8'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{chan: 2'd0, c1: 8'hA5, c2: 8'h11, c3: 8'h22, exp: 8'hA5, hold: 1'b0};
        vecs[1] = '{chan: 2'd1, c1: 8'h11, c2: 8'h3C, c3: 8'h22, exp: 8'h3C, hold: 1'b1};
        vecs[2] = '{chan: 2'd3, c1: 8'hFF, c2: 8'hFF, c3: 8'hFF, exp: 8'h00, hold: 1'b0};
        vecs[3] = '{chan: 2'd2, c1: 8'h00, c2: 8'h00, c3: 8'h5A, exp: 8'h5A, hold: 1'b1};
        vecs[4] = '{chan: 2'd0, c1: 8'h00, c2: 8'hFF, c3: 8'hFF, exp: 8'h00, hold: 1'b0};
        vecs[5] = '{chan: 2'd1, c1: 8'h00, c2: 8'hFF, c3: 8'h00, exp: 8'hFF, hold: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_tx", 0, {7'd0, TX}, 8'd1);
        chk("rst_busy", 0, {7'd0, tx_busy}, 8'd0);
        chk("rst_sent", 0, {7'd0, dump_sent}, 8'd0);
        rst_n = 1'b1;
        idle_chk("post_rst");

        for (int v = 0; v < 6; v++) begin
            start_req(vecs[v].chan, vecs[v].c1, vecs[v].c2, vecs[v].c3);
            frame(vecs[v].exp, vecs[v].hold, 1'b0);
            idle_chk("vec_idle");
            repeat (2) @(negedge clk);
        end

        // back-to-back: new request in the idle cycle right after dump_sent
        start_req(2'd0, 8'h01, 8'h00, 8'h00);
        frame(8'h01, 1'b1, 1'b0);
        idle_chk("b2b0");
        start_req(2'd0, 8'hFF, 8'h00, 8'h00);
        frame(8'hFF, 1'b1, 1'b0);
        idle_chk("b2b1");
        start_req(2'd0, 8'h80, 8'h00, 8'h00);
        frame(8'h80, 1'b1, 1'b0);
        idle_chk("b2b2");

        // inputs change mid-frame; the latched byte must be sent
        repeat (2) @(negedge clk);
        start_req(2'd2, 8'h0F, 8'h00, 8'h55);
        frame(8'h55, 1'b0, 1'b1);
        idle_chk("mut_idle");

        // asynchronous reset in the middle of DATA
        repeat (2) @(negedge clk);
        start_req(2'd0, 8'hA5, 8'h00, 8'h00);
        @(negedge clk);
        send_dump = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_tx", 10, {7'd0, TX}, 8'd0);
        chk("pre_rst_busy", 10, {7'd0, tx_busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", 10, {7'd0, TX}, 8'd1);
        chk("arst_busy", 10, {7'd0, tx_busy}, 8'd0);
        chk("arst_sent", 10, {7'd0, dump_sent}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_rst_sent", i, {7'd0, dump_sent}, 8'd0);
            chk("in_rst_tx", i, {7'd0, TX}, 8'd1);
        end
        rst_n = 1'b1;
        idle_chk("rel_idle");
        start_req(2'd1, 8'h00, 8'h96, 8'h00);
        frame(8'h96, 1'b0, 1'b0);
        idle_chk("post_arst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
